// File: rtl/phase_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phase_drv_pkg
// Description : Shared types and widths for the phase-shift bridge driver.
// Revision    : 1.0 - initial release
// ============================================================================
package phase_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STARTUP = 2'd1,
    ST_RUN     = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam int CNT_W  = 16;
  localparam int PROD_W = 24;

  // Leg B lag in clk cycles: half-period scaled by (255 - phase) / 256.
  function automatic logic [CNT_W-1:0] shift_delay(input logic [CNT_W-1:0] hp,
                                                   input logic [7:0]       ph);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(hp) * PROD_W'(8'd255 - ph);
    return CNT_W'(prod >> 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_shift_driver_leg.sv
`default_nettype none
// ============================================================================
// Module      : deadtime_leg
// Description : One half-bridge leg. A target change drops both gates at the
//               next clk and raises the new side DEADTIME clk later.
// Revision    : 1.0 - initial release
// ============================================================================
module deadtime_leg #(
  parameter int DEADTIME = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kill,
  input  logic target,
  output logic hi,
  output logic lo
);

  localparam int CW = $clog2(DEADTIME + 1);

  logic          side;
  logic [CW-1:0] cnt;

  // Break-before-make sequencing; kill forces both gates off and re-arms the wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      side <= 1'b0;
      cnt  <= '0;
      hi   <= 1'b0;
      lo   <= 1'b0;
    end else if (kill || (target != side)) begin
      hi   <= 1'b0;
      lo   <= 1'b0;
      side <= target;
      cnt  <= CW'(DEADTIME);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        hi <= side;
        lo <= ~side;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/phase_shift_driver.sv
`default_nettype none
// ============================================================================
// Module      : phase_shift_driver
// Description : Zero-cross locked phase-shift full-bridge driver. Leg A follows
//               the resonant current polarity, leg B follows its inverse after
//               a delay set by the conduction angle.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_shift_driver
  import phase_drv_pkg::*;
#(
  parameter int DEADTIME   = 10,
  parameter int HP_MIN     = 50,
  parameter int HP_MAX     = 4000,
  parameter int START_HALF = 400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       zc_in,
  input  logic [7:0] phase_value,
  output logic       cycle_done,
  output logic       gate_a_hi,
  output logic       gate_a_lo,
  output logic       gate_b_hi,
  output logic       gate_b_lo,
  output logic       running,
  output logic       fault
);

  state_t            state;
  logic              zc_s1, zc_s2, zc_s3, rise, fall;
  logic [CNT_W-1:0]  hp_cnt, hp_meas, delay, b_cnt, osc_cnt, cnt_inc, calc_delay;
  logic [7:0]        phase_s;
  logic              osc, acc_q, pol_q, pending, pend_pol, tgt_a, tgt_b;
  logic              live, accept, timeout, kill;

  // hp_meas holds the clk count between accepted edges, so the counter value
  // including the current cycle is what gets compared and captured.
  assign cnt_inc    = (hp_cnt >= CNT_W'(HP_MAX)) ? CNT_W'(HP_MAX) : hp_cnt + CNT_W'(1);
  assign live       = (state == ST_STARTUP) || (state == ST_RUN);
  assign accept     = live && (rise || fall) && (cnt_inc >= CNT_W'(HP_MIN));
  assign timeout    = (state == ST_RUN) && !accept && (cnt_inc >= CNT_W'(HP_MAX));
  assign kill       = !enable || (state == ST_IDLE) || (state == ST_FAULT) || timeout;
  assign calc_delay = shift_delay(hp_meas, phase_s);

  // Two-flop synchroniser followed by a registered edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zc_s1 <= 1'b0;
      zc_s2 <= 1'b0;
      zc_s3 <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      zc_s1 <= zc_in;
      zc_s2 <= zc_s1;
      zc_s3 <= zc_s2;
      rise  <= zc_s2 & ~zc_s3;
      fall  <= ~zc_s2 & zc_s3;
    end
  end

  // Half-period measurement; glitch edges leave every register untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_cnt  <= '0;
      hp_meas <= '0;
      phase_s <= '0;
    end else if (!enable || !live) begin
      hp_cnt <= '0;
    end else if (accept) begin
      hp_cnt  <= '0;
      hp_meas <= cnt_inc;
      if (rise) phase_s <= phase_value;
    end else begin
      hp_cnt <= cnt_inc;
    end
  end

  // Free-running start oscillator, active only while in STARTUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osc_cnt <= '0;
      osc     <= 1'b0;
    end else if (state != ST_STARTUP) begin
      osc_cnt <= '0;
      osc     <= 1'b0;
    end else if (osc_cnt == CNT_W'(START_HALF - 1)) begin
      osc_cnt <= '0;
      osc     <= ~osc;
    end else begin
      osc_cnt <= osc_cnt + CNT_W'(1);
    end
  end

  // Control FSM with registered status outputs and leg targets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      running    <= 1'b0;
      fault      <= 1'b0;
      cycle_done <= 1'b0;
      acc_q      <= 1'b0;
      pol_q      <= 1'b0;
      tgt_a      <= 1'b0;
      tgt_b      <= 1'b0;
      pending    <= 1'b0;
      pend_pol   <= 1'b0;
      delay      <= '0;
      b_cnt      <= '0;
    end else begin
      cycle_done <= 1'b0;
      acc_q      <= 1'b0;
      if (!enable) begin
        state   <= ST_IDLE;
        running <= 1'b0;
        fault   <= 1'b0;
        pending <= 1'b0;
        tgt_a   <= 1'b0;
        tgt_b   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_STARTUP;
            running <= 1'b1;
          end
          ST_STARTUP: begin
            tgt_a <= osc;
            tgt_b <= ~osc;
            if (accept) begin
              state <= ST_RUN;
              acc_q <= 1'b1;
              pol_q <= rise;
            end
          end
          ST_RUN: begin
            if (timeout) begin
              state   <= ST_FAULT;
              running <= 1'b0;
              fault   <= 1'b1;
              pending <= 1'b0;
            end else begin
              if (accept) begin
                acc_q      <= 1'b1;
                pol_q      <= rise;
                cycle_done <= rise;
              end
              // The cycle after acceptance the new delay is known: leg A moves,
              // any leftover leg B update is flushed and the new lag starts.
              if (acc_q) begin
                tgt_a <= pol_q;
                delay <= calc_delay;
                if (calc_delay == '0) begin
                  tgt_b   <= ~pol_q;
                  pending <= 1'b0;
                end else begin
                  if (pending) tgt_b <= pend_pol;
                  pending  <= 1'b1;
                  pend_pol <= ~pol_q;
                  b_cnt    <= CNT_W'(1);
                end
              end else if (pending) begin
                if (b_cnt == delay) begin
                  tgt_b   <= pend_pol;
                  pending <= 1'b0;
                end else begin
                  b_cnt <= b_cnt + CNT_W'(1);
                end
              end
            end
          end
          ST_FAULT: begin
            state <= ST_FAULT;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  deadtime_leg #(.DEADTIME(DEADTIME)) u_leg_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .kill   (kill),
    .target (tgt_a),
    .hi     (gate_a_hi),
    .lo     (gate_a_lo)
  );

  deadtime_leg #(.DEADTIME(DEADTIME)) u_leg_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .kill   (kill),
    .target (tgt_b),
    .hi     (gate_b_hi),
    .lo     (gate_b_lo)
  );

endmodule
`default_nettype wire

// File: tb/tb_phase_shift_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_shift_driver
// Description : Self-checking bench for phase_shift_driver with a behavioural
//               lag model driven by randomized half-periods and phase values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_shift_driver;

  logic       clk = 1'b0;
  logic       rst_n, enable, zc_in;
  logic [7:0] phase_value;
  logic       cycle_done, gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo, running, fault;

  int passed = 0, total = 0, failed = 0;

  // model state
  int     prev_h = 200, p_lat = 128, rises = 0;
  bit     measuring = 1'b0;
  longint t_tog = 0;
  int     exp_lag[$];

  // monitor state
  longint qa[$], qb[$];
  int     overlap = 0, dt_viol = 0, cd_count = 0, cd_consec = 0;
  int     off_run[2] = '{0, 0};
  logic [1:0] p_hi = '0, p_lo = '0;
  logic       p_cd = 1'b0;

  phase_shift_driver #(
    .DEADTIME(4), .HP_MIN(20), .HP_MAX(1000), .START_HALF(100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .zc_in       (zc_in),
    .phase_value (phase_value),
    .cycle_done  (cycle_done),
    .gate_a_hi   (gate_a_hi),
    .gate_a_lo   (gate_a_lo),
    .gate_b_hi   (gate_b_hi),
    .gate_b_lo   (gate_b_lo),
    .running     (running),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Leg safety, drop-event timestamps and cycle_done statistics.
  always @(negedge clk) begin
    logic [1:0] hi, lo;
    hi = {gate_b_hi, gate_a_hi};
    lo = {gate_b_lo, gate_a_lo};
    for (int l = 0; l < 2; l++) begin
      if (hi[l] && lo[l]) overlap++;
      if ((hi[l] && !p_hi[l]) || (lo[l] && !p_lo[l]))
        if (p_hi[l] || p_lo[l] || off_run[l] < 4) dt_viol++;
      if ((p_hi[l] || p_lo[l]) && !(hi[l] || lo[l])) begin
        if (l == 0) qa.push_back(longint'($time / 10));
        else        qb.push_back(longint'($time / 10));
      end
      off_run[l] = (hi[l] || lo[l]) ? 0 : off_run[l] + 1;
    end
    p_hi = hi;
    p_lo = lo;
    if (cycle_done) begin
      cd_count++;
      if (p_cd) cd_consec++;
    end
    p_cd = cycle_done;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One zc half-cycle of length h; the model predicts the leg B lag for the
  // edge that starts it from the previous half-period and the held phase.
  task automatic half_cycle(input int h, input int p_next, input bit glitch);
    int p_eff;
    zc_in = ~zc_in;
    if (zc_in) begin
      p_eff = int'(phase_value);
      p_lat = p_eff;
      if (measuring) rises++;
    end else begin
      p_eff = p_lat;
    end
    if (measuring) exp_lag.push_back((prev_h * (255 - p_eff)) >> 8);
    t_tog = $time;
    if (glitch) begin
      tick(8);
      zc_in = ~zc_in;
      tick(5);
      zc_in = ~zc_in;
      tick(37);
    end else begin
      tick(50);
    end
    phase_value = 8'(p_next);
    tick(h - 50);
    prev_h = h;
  endtask

  initial begin
    longint lat;
    int     waited;
    int     n;

    rst_n = 1'b0; enable = 1'b0; zc_in = 1'b0; phase_value = 8'd128;
    tick(3);
    check("reset_gates", {gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo}, 0);
    check("reset_cycle_done", cycle_done, 0);
    check("reset_running", running, 0);
    check("reset_fault", fault, 0);

    rst_n = 1'b1;
    tick(3);
    check("idle_running", running, 0);
    check("idle_gates", {gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo}, 0);

    enable = 1'b1;
    tick(2);
    check("startup_running", running, 1);
    check("startup_fault", fault, 0);
    // Oscillator toggles 100 clk into STARTUP; legs switch together (no lag).
    tick(148);
    check("startup_leg_a", {gate_a_hi, gate_a_lo}, 2'b10);
    check("startup_leg_b", {gate_b_hi, gate_b_lo}, 2'b01);

    for (int i = 0; i < 6; i++) half_cycle(200, 128, 1'b0);
    check("run_running", running, 1);
    check("run_fault", fault, 0);

    qa.delete(); qb.delete(); cd_count = 0; measuring = 1'b1;
    for (int i = 0; i < 6; i++) half_cycle(200, (i == 5) ? 255 : 128, i == 2);
    for (int i = 0; i < 5; i++) half_cycle(200, 255, 1'b0);
    for (int i = 0; i < 16; i++)
      half_cycle(int'($urandom_range(180, 240)), int'($urandom_range(100, 255)),
                 $urandom_range(0, 3) == 0);
    half_cycle(200, 0, 1'b0);
    for (int i = 0; i < 5; i++) half_cycle(200, 0, 1'b0);
    tick(10);

    check("leg_a_events", qa.size(), exp_lag.size());
    check("leg_b_events", qb.size(), exp_lag.size());
    n = exp_lag.size();
    if (qa.size() < n) n = qa.size();
    if (qb.size() < n) n = qb.size();
    for (int i = 0; i < n; i++) check($sformatf("lag_%0d", i), qb[i] - qa[i], exp_lag[i]);
    check("cycle_done_count", cd_count, rises);
    check("cycle_done_consecutive", cd_consec, 0);

    // zc stopped: timeout must latch FAULT about HP_MAX clk after the last edge
    waited = 0;
    while (!fault && waited < 1100) begin
      tick(1);
      waited++;
    end
    lat = ($time - t_tog) / 10;
    check("fault_asserted", fault, 1);
    check("fault_latency_window", (lat >= 1000 && lat <= 1010), 1);
    check("fault_gates", {gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo}, 0);
    check("fault_running", running, 0);
    tick(20);
    check("fault_latched", fault, 1);
    enable = 1'b0;
    tick(1);
    check("disable_fault_clear", fault, 0);
    check("disable_running", running, 0);

    // Reset asserted mid-RUN while a leg B update is pending
    measuring = 1'b0;
    enable = 1'b1;
    phase_value = 8'd128;
    for (int i = 0; i < 4; i++) half_cycle(200, 128, 1'b0);
    check("rerun_running", running, 1);
    zc_in = ~zc_in;
    tick(30);
    #3 rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("async_reset_gates", {gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo}, 0);
    check("async_reset_running", running, 0);
    check("async_reset_cycle_done", cycle_done, 0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("post_reset_idle", running, 0);
    check("post_reset_gates", {gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo}, 0);
    enable = 1'b1;
    tick(2);
    check("post_reset_startup", running, 1);

    check("no_gate_overlap", overlap, 0);
    check("deadtime_gaps", dt_viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/phase_shift_driver.md
PHASE_SHIFT_DRIVER -- requirements
Module: phase_shift_driver

Interface
REQ-001 Parameter DEADTIME, default 10: clk cycles with both gates of a leg off on every leg transition.
REQ-002 Parameter HP_MIN, default 50: minimum accepted half-period in clk cycles; shorter edges are glitches.
REQ-003 Parameter HP_MAX, default 4000: half-period timeout in clk cycles; exceeding it in RUN is a fault.
REQ-004 Parameter START_HALF, default 400: internal start-oscillator half-period in clk cycles.
REQ-005 clk  in  1  single system clock; all logic is on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 enable  in  1  level; 1 = drive the bridge, 0 = stop.
REQ-008 zc_in  in  1  asynchronous resonant-current zero-cross comparator; polarity of primary current.
REQ-009 phase_value  in  8  conduction angle from the ramp stage; 255 = full power, 0 = minimum.
REQ-010 cycle_done  out  1  one-clk pulse per accepted rising zc edge in RUN; feeds the ramp stage.
REQ-011 gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo  out  1 each  bridge gate commands, active high.
REQ-012 running  out  1  high in STARTUP or RUN.
REQ-013 fault  out  1  high in FAULT.

Function
REQ-014 zc_in SHALL pass a 2-flop synchroniser then a registered edge detector; an edge is visible internally 3 clk after the zc_in transition.
REQ-015 16-bit hp_cnt SHALL count clk since the last accepted edge, saturating at HP_MAX.
REQ-016 An edge SHALL be accepted only if hp_cnt >= HP_MIN; on acceptance hp_meas <= hp_cnt, hp_cnt <= 0; rejected edges change no state.
REQ-017 phase_value SHALL be sampled once per accepted rising edge and held for the whole cycle.
REQ-018 delay SHALL be (hp_meas * (255 - phase_sampled)) >> 8, 24-bit product, registered 1 clk after the edge, result <= hp_meas.
REQ-019 Leg A target SHALL equal the accepted polarity; leg B target SHALL be its inverse delayed by delay clk cycles.
REQ-020 If a new accepted edge arrives while a leg B update is pending, the pending update SHALL apply immediately and the new delay SHALL start.
REQ-021 Each leg SHALL on a target change drop both gates at the next clk, then raise the new side DEADTIME clk later; hi and lo SHALL never both be 1.
REQ-022 FSM states: IDLE, STARTUP, RUN, FAULT.
REQ-023 IDLE: all gates 0; enable=1 -> STARTUP.
REQ-024 STARTUP: polarity from internal oscillator toggling every START_HALF clk, delay = 0, no cycle_done; first accepted zc edge -> RUN.
REQ-025 RUN: polarity from zc; hp_cnt reaching HP_MAX -> FAULT.
REQ-026 FAULT: all gates 0, fault=1, latched until enable=0.
REQ-027 enable=0 in any state SHALL go to IDLE next clk with all gates 0 that same clk, bypassing deadtime.
REQ-028 cycle_done SHALL pulse for exactly one clk, coincident with the accepted rising edge, never in two consecutive clk.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, all gates 0, cycle_done 0, running 0, fault 0, counters 0, hp_meas 0.
REQ-030 Deassertion mid-operation SHALL restart from IDLE; no pending leg B update survives reset.

Structure
REQ-031 Package phase_drv_pkg SHALL hold the FSM state enum, counter width (16) and product width (24).
REQ-032 One sub-module deadtime_leg (target in, hi/lo out, DEADTIME parameter) SHALL be instanced twice.

Verification (DEADTIME=4, HP_MIN=20, HP_MAX=1000, START_HALF=100)
REQ-033 Reset asserted mid-RUN -> all outputs 0 in the same cycle; state IDLE after release.
REQ-034 enable=1, zc square wave half-period 200, phase_value=128 -> RUN; leg B transitions 99 clk after leg A target (200*127>>8), one cycle_done per zc period.
REQ-035 phase_value=255 -> delay 0; phase_value=0 -> delay 199; values change only at rising edges.
REQ-036 5-clk glitch pulse on zc_in mid half-cycle -> ignored, no cycle_done, hp_meas unchanged.
REQ-037 zc stops in RUN -> FAULT after 1000 clk, gates 0, fault=1; enable=0 -> IDLE, fault=0.
REQ-038 All scenarios: each leg never has hi=lo=1 and shows a >=4-clk both-off gap at every transition.
